// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the n-bit serial pattern detector.
package seq_det_pkg;

   // Widest beat and widest counter the helpers below are sized for.
   localparam int unsigned MAX_LANES = 8;
   localparam int unsigned MAX_CNT_W = 32;

   // Width of a length field able to hold 0..pat_max.
   function automatic int unsigned len_width(input int unsigned pat_max);
      return unsigned'($clog2(pat_max + 1));
   endfunction

   // cnt + popcount(lanes), clamped to cnt_max; written so it never wraps.
   function automatic logic [MAX_CNT_W-1:0] sat_add_pop(
      input logic [MAX_CNT_W-1:0] cnt,
      input logic [MAX_LANES-1:0] lanes,
      input logic [MAX_CNT_W-1:0] cnt_max
   );
      logic [MAX_CNT_W-1:0] pop;
      pop = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         pop = pop + MAX_CNT_W'(lanes[i]);
      end
      if (pop > cnt_max - cnt) begin
         return cnt_max;
      end
      return cnt + pop;
   endfunction

endpackage

// File: rtl/seq_detector_nbit_lane_cmp.sv
// Masked compare of one PAT_MAX-bit window against the pattern's low len bits.
// window[0] is the latest bit; the compare is false for len 0 or len > PAT_MAX.
module seq_lane_cmp #(
   parameter int unsigned PAT_MAX = 16,
   parameter int unsigned LEN_W   = 5
) (
   input  logic [PAT_MAX-1:0] window,
   input  logic [PAT_MAX-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   output logic               hit
);

   logic        diff;
   int unsigned len_i;

   // Accumulate mismatches over the bits selected by len.
   always_comb begin
      diff  = 1'b0;
      len_i = 32'(len);
      for (int unsigned k = 0; k < PAT_MAX; k++) begin
         if (k < len_i) begin
            diff = diff | (window[k] ^ pattern[k]);
         end
      end
      hit = (len_i != 0) && (len_i <= PAT_MAX) && !diff;
   end

endmodule

// File: rtl/seq_detector_nbit.sv
// Runtime-programmable serial pattern detector, LANES bits per beat.
// data[LANES-1] is earliest in time; match_lanes[i] flags a pattern ending at data[i].
module seq_detector_nbit
   import seq_det_pkg::*;
#(
   parameter int unsigned LANES   = 2,
   parameter int unsigned PAT_MAX = 16,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cfg_en,
   input  logic [PAT_MAX-1:0]           cfg_pattern,
   input  logic [$clog2(PAT_MAX+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         data_vld,
   input  logic [LANES-1:0]             data,
   input  logic                         cnt_clr,
   output logic                         match,
   output logic [LANES-1:0]             match_lanes,
   output logic [CNT_W-1:0]             match_cnt
);

   localparam int unsigned LEN_W = len_width(PAT_MAX);

   logic [PAT_MAX-1:0]       hist;
   logic [PAT_MAX+LANES-1:0] win;
   logic [LEN_W-1:0]         fcnt;
   logic [LEN_W-1:0]         fcnt_nx;
   logic [LANES-1:0]         eq;
   logic [LANES-1:0]         lanes_nx;
   logic [LANES-1:0]         beat_lanes;
   logic [CNT_W-1:0]         cnt_nx;
   int unsigned              fill;
   int unsigned              len_i;
   int unsigned              lane;

   // Older history above the current beat; window for lane i is win[i +: PAT_MAX].
   assign win = {hist, data};

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      seq_lane_cmp #(
         .PAT_MAX(PAT_MAX),
         .LEN_W  (LEN_W)
      ) u_cmp (
         .window (win[g +: PAT_MAX]),
         .pattern(cfg_pattern),
         .len    (cfg_len),
         .hit    (eq[g])
      );
   end

   // Walk lanes in time order, carrying the fill count; a non-overlap match
   // restarts the fill so later lanes of the same beat need fresh bits.
   always_comb begin
      fill     = 32'(fcnt);
      len_i    = 32'(cfg_len);
      lane     = 0;
      lanes_nx = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         lane = LANES - 1 - k;
         if (fill < PAT_MAX) begin
            fill = fill + 1;
         end
         if (eq[lane] && (fill >= len_i)) begin
            lanes_nx[lane] = 1'b1;
            if (!cfg_overlap) begin
               fill = 0;
            end
         end
      end
      fcnt_nx    = LEN_W'(fill);
      beat_lanes = (cfg_en && data_vld) ? lanes_nx : '0;
   end

   // Saturating counter update; clear wins over this beat's matches.
   always_comb begin
      if (cnt_clr) begin
         cnt_nx = '0;
      end else begin
         cnt_nx = CNT_W'(sat_add_pop(MAX_CNT_W'(match_cnt),
                                     MAX_LANES'(beat_lanes),
                                     MAX_CNT_W'({CNT_W{1'b1}})));
      end
   end

   // History and fill advance on valid beats and clear while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist <= '0;
         fcnt <= '0;
      end else if (!cfg_en) begin
         hist <= '0;
         fcnt <= '0;
      end else if (data_vld) begin
         hist <= win[PAT_MAX-1:0];
         fcnt <= fcnt_nx;
      end
   end

   // Registered match outputs and counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match       <= 1'b0;
         match_lanes <= '0;
         match_cnt   <= '0;
      end else begin
         match       <= |beat_lanes;
         match_lanes <= beat_lanes;
         match_cnt   <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_seq_detector_nbit.sv
// Randomised and directed bench for seq_detector_nbit against a bit-queue model.
module tb_seq_detector_nbit;

   localparam int unsigned LANES   = 2;
   localparam int unsigned PAT_MAX = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 cfg_en;
   logic [PAT_MAX-1:0]   cfg_pattern;
   logic [4:0]           cfg_len;
   logic                 cfg_overlap;
   logic                 data_vld;
   logic [LANES-1:0]     data;
   logic                 cnt_clr;
   logic                 match, match_s;
   logic [LANES-1:0]     match_lanes, match_lanes_s;
   logic [7:0]           match_cnt;
   logic [1:0]           match_cnt_s;

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   // Model state: bits since last clear, fresh bits since last fill restart.
   bit          q[$];
   int unsigned fresh;
   int unsigned exp_cnt8;
   int unsigned exp_cnt2;

   always #5 clk = ~clk;

   seq_detector_nbit #(.LANES(LANES), .PAT_MAX(PAT_MAX), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_vld(data_vld),
      .data(data), .cnt_clr(cnt_clr), .match(match),
      .match_lanes(match_lanes), .match_cnt(match_cnt)
   );

   seq_detector_nbit #(.LANES(LANES), .PAT_MAX(PAT_MAX), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .data_vld(data_vld),
      .data(data), .cnt_clr(cnt_clr), .match(match_s),
      .match_lanes(match_lanes_s), .match_cnt(match_cnt_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_clear();
      q.delete();
      fresh = 0;
   endfunction

   function automatic logic [LANES-1:0] model_beat(input logic [LANES-1:0] d);
      logic [LANES-1:0] r;
      bit               ok;
      int unsigned      len;
      r   = '0;
      len = cfg_len;
      for (int k = LANES - 1; k >= 0; k--) begin
         q.push_back(d[k]);
         if (q.size() > 40) void'(q.pop_front());
         fresh++;
         if (len >= 1 && len <= PAT_MAX && fresh >= len) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < len; j++) begin
               if (q[q.size() - 1 - j] != cfg_pattern[j]) ok = 1'b0;
            end
            if (ok) begin
               r[k] = 1'b1;
               if (!cfg_overlap) fresh = 0;
            end
         end
      end
      return r;
   endfunction

   function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
      return (v > mx) ? mx : v;
   endfunction

   // Apply one cycle of inputs, advance the model, check both DUTs after the edge.
   task automatic step(input logic en, input logic vld, input logic [LANES-1:0] d, input logic clr);
      logic [LANES-1:0] exp_l;
      int unsigned      pop;
      cfg_en   = en;
      data_vld = vld;
      data     = d;
      cnt_clr  = clr;
      exp_l    = '0;
      if (!en) model_clear();
      else if (vld) exp_l = model_beat(d);
      pop = $countones(exp_l);
      exp_cnt8 = clr ? 0 : sat(exp_cnt8 + pop, 255);
      exp_cnt2 = clr ? 0 : sat(exp_cnt2 + pop, 3);
      @(posedge clk);
      #1;
      check("lanes", 32'(match_lanes), 32'(exp_l));
      check("match", 32'(match), 32'(|exp_l));
      check("cnt8", 32'(match_cnt), exp_cnt8);
      check("cnt2", 32'(match_cnt_s), exp_cnt2);
      check("lanes_sat", 32'(match_lanes_s), 32'(exp_l));
   endtask

   task automatic configure(input logic [PAT_MAX-1:0] pat, input int unsigned len, input logic ovl);
      step(1'b0, 1'b0, '0, 1'b0);
      cfg_pattern = pat;
      cfg_len     = 5'(len);
      cfg_overlap = ovl;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_clear();
      exp_cnt8 = 0;
      exp_cnt2 = 0;
      #1;
      check("rst_lanes", 32'(match_lanes), 32'd0);
      check("rst_match", 32'(match), 32'd0);
      check("rst_cnt", 32'(match_cnt), 32'd0);
      check("rst_cnt_sat", 32'(match_cnt_s), 32'd0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      cfg_en = 1'b0; data_vld = 1'b0; data = '0; cnt_clr = 1'b0;
      cfg_pattern = 16'b1011001; cfg_len = 5'd7; cfg_overlap = 1'b1;
      model_clear();
      exp_cnt8 = 0; exp_cnt2 = 0;
      #3;
      do_reset();

      // Legacy 7-bit pattern over 2-bit beats.
      step(1, 1, 2'b10, 0); step(1, 1, 2'b11, 0); step(1, 1, 2'b00, 0);
      step(1, 1, 2'b11, 0);
      check("legacy_lanes", 32'(match_lanes), 32'b10);
      check("legacy_cnt", 32'(match_cnt), 32'd1);

      // Overlap vs non-overlap on pattern 11.
      configure(16'b11, 2, 1'b1);
      step(0, 0, 2'b00, 1);
      step(1, 1, 2'b11, 0);
      check("ovl1_b1", 32'(match_lanes), 32'b01);
      step(1, 1, 2'b11, 0);
      check("ovl1_b2", 32'(match_lanes), 32'b11);
      check("ovl1_cnt", 32'(match_cnt), 32'd3);
      configure(16'b11, 2, 1'b0);
      step(0, 0, 2'b00, 1);
      step(1, 1, 2'b11, 0);
      check("ovl0_b1", 32'(match_lanes), 32'b01);
      step(1, 1, 2'b11, 0);
      check("ovl0_b2", 32'(match_lanes), 32'b01);
      check("ovl0_cnt", 32'(match_cnt), 32'd2);

      // Leading-zero pattern straight after reset.
      cfg_en = 1'b0;
      cfg_pattern = 16'b001; cfg_len = 5'd3; cfg_overlap = 1'b1;
      @(posedge clk); #3;
      do_reset();
      step(1, 1, 2'b01, 0);
      check("lz_b1", 32'(match), 32'd0);
      step(1, 1, 2'b00, 0);
      check("lz_b2", 32'(match), 32'd0);
      step(1, 1, 2'b10, 0);
      check("lz_b3", 32'(match_lanes), 32'b10);

      // Enable dropped mid-pattern.
      configure(16'b1011001, 7, 1'b1);
      step(1, 1, 2'b10, 0); step(1, 1, 2'b11, 0);
      step(0, 1, 2'b00, 0);
      step(1, 1, 2'b00, 0); step(1, 1, 2'b11, 0);
      check("en_drop", 32'(match), 32'd0);

      // Valid gaps between every beat.
      configure(16'b1011001, 7, 1'b1);
      step(1, 1, 2'b10, 0); step(1, 0, 2'b01, 0);
      step(1, 1, 2'b11, 0); step(1, 0, 2'b10, 0);
      step(1, 1, 2'b00, 0); step(1, 0, 2'b11, 0);
      step(1, 1, 2'b11, 0);
      check("gap_lanes", 32'(match_lanes), 32'b10);
      step(1, 0, 2'b11, 0);
      check("gap_idle", 32'(match), 32'd0);

      // Saturation and clear priority.
      configure(16'b1, 1, 1'b1);
      step(0, 0, 2'b00, 1);
      step(1, 1, 2'b11, 0);
      check("sat_1", 32'(match_cnt_s), 32'd2);
      step(1, 1, 2'b11, 0);
      check("sat_2", 32'(match_cnt_s), 32'd3);
      step(1, 1, 2'b11, 0);
      check("sat_3", 32'(match_cnt_s), 32'd3);
      check("sat_wide", 32'(match_cnt), 32'd6);
      step(1, 1, 2'b11, 1);
      check("clr_prio", 32'(match_cnt), 32'd0);
      check("clr_prio_lanes", 32'(match_lanes), 32'b11);

      // Async reset mid-stream.
      configure(16'b1011001, 7, 1'b1);
      step(1, 1, 2'b11, 0);
      step(1, 1, 2'b10, 0); step(1, 1, 2'b11, 0);
      #3;
      do_reset();
      step(1, 1, 2'b00, 0); step(1, 1, 2'b11, 0);
      check("rst_mid", 32'(match), 32'd0);

      // Random traffic with periodic reconfiguration.
      for (int unsigned n = 0; n < 600; n++) begin
         if (n % 60 == 0) begin
            int unsigned l;
            l = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 4);
            configure(PAT_MAX'($urandom), l, 1'($urandom));
         end
         step(($urandom_range(0, 40) != 0), ($urandom_range(0, 4) != 0),
              LANES'($urandom), ($urandom_range(0, 30) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/seq_detector_nbit.md
Name: seq_detector_nbit

Overview:
Runtime-programmable serial pattern detector that consumes LANES bits per clock and reports every lane position where a pattern of up to PAT_MAX bits completes. It generalises the fixed 2-bit/7-bit detector to any lane count, any pattern and length, selectable overlap/non-overlap matching, and a saturating match counter. It sits on the same serial-data front end as the existing fixed detector, between the deserialiser and the framing/alarm logic.

Parameters:
LANES, 2, bits consumed per valid beat (1..8)
PAT_MAX, 16, maximum pattern length in bits (>= LANES)
CNT_W, 8, width of the saturating match counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cfg_en  in  1  detector enable; low clears history
cfg_pattern  in  PAT_MAX  pattern; bit cfg_len-1 is first in time, bit 0 is last
cfg_len  in  $clog2(PAT_MAX+1)  pattern length in bits
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
data_vld  in  1  beat qualifier
data  in  LANES  input bits; data[LANES-1] is earliest in time, data[0] latest
cnt_clr  in  1  synchronous clear of match_cnt
match  out  1  registered: any lane matched on the previous valid beat
match_lanes  out  LANES  registered: bit i set if the pattern ends at data[i] of the previous beat
match_cnt  out  CNT_W  saturating total of matches

Behaviour:
- Reset: match=0, match_lanes=0, match_cnt=0, history=0, fill count=0.
- History: shift register of PAT_MAX+LANES-1 bits plus fill count fcnt (bits since enable/reset/last non-overlap match), saturating at PAT_MAX.
- Per valid beat, evaluate lanes in time order (i = LANES-1 down to 0). Lane i matches iff the last cfg_len bits ending at data[i] equal cfg_pattern[cfg_len-1:0] and the running fill at that lane >= cfg_len.
- Overlap=1: fill is unaffected by matches; all qualifying lanes are reported.
- Overlap=0: a match at lane i resets the running fill to 0 from lane i-1 onward. Later lanes in the same beat need cfg_len fresh bits.
- Latency: match/match_lanes are valid exactly one clk after the beat. match = |match_lanes.
- data_vld=0: history and fcnt hold; match/match_lanes are 0 next cycle.
- cfg_en=0: fcnt and history clear; match/match_lanes are 0 next cycle; match_cnt holds. The first beat after re-enable needs a full cfg_len fresh bits.
- cfg_len==0 or cfg_len>PAT_MAX: never match. History still shifts.
- cfg_pattern/cfg_len/cfg_overlap change only while cfg_en=0. Behaviour for changes made while enabled is undefined.
- match_cnt: adds popcount(match_lanes) in the same cycle match_lanes registers, and saturates at 2^CNT_W-1. cnt_clr has priority: the counter becomes 0 that cycle and that beat's matches are discarded from the count.
- No false matches on reset zeros: guaranteed by fcnt, including for patterns that begin with 0.

Decomposition:
- Package seq_det_pkg: lane-ordering convention constants, a function computing popcount with saturating add, and a function computing the length width from PAT_MAX.
- One sub-module, seq_lane_cmp: a combinational masked compare of a PAT_MAX window against the pattern under cfg_len. It is instantiated LANES times.
- The top level holds the history, fcnt, non-overlap lane chain and registers.

Test Plan:
- Legacy-compatibility check (LANES=2, pattern 7'b1011001, len 7, overlap=1). Drive the beats 10,11,00,11. Expect match_lanes=2'b10 one cycle after beat 4 and match_cnt=1.
- Overlap vs non-overlap (pattern 2'b11, len 2). Drive beats 11,11.
  - overlap=1: lanes 01 then 11, match_cnt=3.
  - overlap=0: lanes 01 then 01, match_cnt=2.
- Leading-zero pattern after reset (pattern 3'b001, len 3). Drive the first beat 01.
  - Expect no match, since fill is 2.
  - Next beat 00: expect no match.
  - Next beat 10: expect lanes 10.
- cfg_en dropped mid-pattern (1011001 partially received after 10,11). Take cfg_en low for one cycle, re-enable, then drive 00,11. Expect no match.
- data_vld gaps (1011001 received with data_vld=0 cycles inserted between every beat). Expect an identical single match and match=0 on all idle cycles.
- Saturation and clear (CNT_W=2, pattern 1'b1, len 1, data 11 each beat). Expect match_cnt 2 then 3 then 3. Pulse cnt_clr in the same cycle as a match: expect match_cnt=0.
- Async reset mid-stream: assert rst_n low between beats. Expect all outputs 0 immediately and no match using pre-reset bits.
